hamming_serial_decoder: RTL and testbench

- Parametrised serial Hamming decoder. Shifts in one codeword bit per accepted strobe and builds the syndrome incrementally.
- At end of frame it corrects a single-bit error and, in extended mode, flags double-bit errors (SECDED).
- Sits between the serial link receiver and the display/consumer logic.
- Successor to the fixed (7,4) strobe-clocked decoder: fully synchronous, any R, optional SECDED, explicit handshake and error statistics.

---
 rtl/hamming_serial_decoder_pkg.sv | 20 ++
 rtl/hamming_serial_decoder_if.sv | 25 ++
 rtl/hamming_serial_decoder_corrector.sv | 27 ++
 rtl/hamming_serial_decoder.sv | 89 ++++++++
 tb/tb_hamming_serial_decoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hamming_serial_decoder_pkg.sv
// hamming_pkg: shared Hamming geometry helpers and decoder state type
package hamming_pkg;
  typedef enum logic {COLLECT, CORRECT} state_t;
  function automatic int calc_n(input int r);
    return (1 << r) - 1;
  endfunction
  function automatic int calc_k(input int r);
    return (1 << r) - 1 - r;
  endfunction
  function automatic bit is_pow2(input int p);
    return p > 0 && (p & (p - 1)) == 0;
  endfunction
  // data_out MSB holds the lowest data position, LSB holds position N
  function automatic int data_index(input int r, input int p);
    int below;
    below = 0;
    for (int i = 1; i < p; i++) if (!is_pow2(i)) below++;
    return calc_k(r) - 1 - below;
  endfunction
endpackage

// File: rtl/hamming_serial_decoder_if.sv
// hamming_serial_decoder_if: serial bit input and decoded result bundle
interface hamming_serial_decoder_if #(parameter int R = 3, parameter int CNT_W = 8);
  localparam int K = hamming_pkg::calc_k(R);
  logic bit_in;
  logic bit_valid_in;
  logic frame_start_in;
  logic in_ready_out;
  logic [K-1:0] data_out;
  logic data_valid_out;
  logic [R-1:0] syndrome_out;
  logic err_corrected_out;
  logic err_uncorrectable_out;
  logic overrun_out;
  logic [CNT_W-1:0] corr_count_out;
  modport master (
    output bit_in, bit_valid_in, frame_start_in,
    input in_ready_out, data_out, data_valid_out, syndrome_out,
    input err_corrected_out, err_uncorrectable_out, overrun_out, corr_count_out
  );
  modport slave (
    input bit_in, bit_valid_in, frame_start_in,
    output in_ready_out, data_out, data_valid_out, syndrome_out,
    output err_corrected_out, err_uncorrectable_out, overrun_out, corr_count_out
  );
endinterface

// File: rtl/hamming_serial_decoder_corrector.sv
// hamming_corrector: classifies a received codeword and extracts corrected data
module hamming_corrector
  import hamming_pkg::*;
#(
  parameter int R = 3,
  parameter int EXTENDED = 0
) (
  input  logic [calc_n(R):1]   word,
  input  logic [R-1:0]         syndrome,
  input  logic                 parity_bad,
  output logic [calc_k(R)-1:0] data,
  output logic                 corrected,
  output logic                 uncorrectable
);
  localparam int N = calc_n(R);
  logic nz, flip, unused_word;
  assign nz = |syndrome;
  assign corrected = EXTENDED != 0 ? parity_bad : nz;
  assign uncorrectable = EXTENDED != 0 && nz && !parity_bad;
  assign flip = nz && (EXTENDED == 0 || parity_bad);
  assign unused_word = ^word;
  for (genvar p = 3; p <= N; p++) begin : g_data
    if (!is_pow2(p)) begin : g_bit
      assign data[data_index(R, p)] = word[p] ^ (flip && syndrome == R'(p));
    end
  end
endmodule

// File: rtl/hamming_serial_decoder.sv
// hamming_serial_decoder: serial Hamming/SECDED decoder with incremental syndrome
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int R = 3,
  parameter int EXTENDED = 0,
  parameter int CNT_W = 8
) (
  input logic clk_in,
  input logic rst_n_in,
  hamming_serial_decoder_if.slave bus
);
  localparam int N = calc_n(R);
  localparam int K = calc_k(R);
  localparam int L = N + EXTENDED;
  state_t state, state_nx;
  logic [R:0] cnt, pos;
  logic [R-1:0] syn, syn_r;
  logic par, ready, accept, last;
  logic [N:1] word;
  logic [K-1:0] fix_data, data_r;
  logic fix_corr, fix_unc, corr_r, unc_r, dv_r, ovr_r;
  logic [CNT_W-1:0] cnt_r;
  hamming_corrector #(.R(R), .EXTENDED(EXTENDED)) u_corr (
    .word(word),
    .syndrome(syn),
    .parity_bad(par),
    .data(fix_data),
    .corrected(fix_corr),
    .uncorrectable(fix_unc)
  );
  always_comb begin
    ready = state == COLLECT;
    accept = bus.bit_valid_in & ready;
    pos = bus.frame_start_in ? (R+1)'(1) : cnt + 1'b1;
    last = accept && pos == (R+1)'(L);
    state_nx = last ? CORRECT : COLLECT;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= COLLECT;
    else state <= state_nx;
  // the overall parity bit lands at pos 2^R, whose low R bits are 0, so it never disturbs the syndrome
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      syn <= '0;
      par <= 1'b0;
      word <= '0;
    end else if (state == CORRECT || (!accept && bus.frame_start_in)) begin
      cnt <= '0;
      syn <= '0;
      par <= 1'b0;
    end else if (accept) begin
      cnt <= pos;
      syn <= (bus.frame_start_in ? '0 : syn) ^ (bus.bit_in ? pos[R-1:0] : '0);
      par <= (bus.frame_start_in ? 1'b0 : par) ^ bus.bit_in;
      if (pos <= (R+1)'(N)) word[pos[R-1:0]] <= bus.bit_in;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_r <= '0;
      syn_r <= '0;
      corr_r <= 1'b0;
      unc_r <= 1'b0;
      dv_r <= 1'b0;
      ovr_r <= 1'b0;
      cnt_r <= '0;
    end else begin
      dv_r <= state == CORRECT;
      ovr_r <= ovr_r | (bus.bit_valid_in & ~ready);
      if (state == CORRECT) begin
        data_r <= fix_data;
        syn_r <= syn;
        corr_r <= fix_corr;
        unc_r <= fix_unc;
        cnt_r <= cnt_r + CNT_W'(fix_corr & ~&cnt_r);
      end
    end
  end
  assign bus.in_ready_out = ready;
  assign bus.data_out = data_r;
  assign bus.data_valid_out = dv_r;
  assign bus.syndrome_out = syn_r;
  assign bus.err_corrected_out = corr_r;
  assign bus.err_uncorrectable_out = unc_r;
  assign bus.overrun_out = ovr_r;
  assign bus.corr_count_out = cnt_r;
endmodule

// File: tb/tb_hamming_serial_decoder.sv
// tb_hamming_serial_decoder: three decoder configurations against a position-arithmetic model
module tb_hamming_serial_decoder;
  typedef struct {logic [15:0] data; logic [3:0] syn; logic corr; logic unc;} res_t;
  typedef struct {int d; logic [15:0] seq; res_t exp;} vec_t;
  logic clk = 0, rst_n = 0;
  logic [2:0] b = '0, v = '0, f = '0;
  logic [2:0] rdy, dv, corr, unc, ovr;
  logic [15:0] dat [3];
  logic [3:0] syn [3];
  logic [7:0] cnt [3];
  int errors = 0, checks = 0;
  int exp_cnt [3] = '{0, 0, 0};
  int rr [3] = '{3, 3, 4};
  int ee [3] = '{0, 1, 0};
  vec_t tbl [9];
  always #5 clk = ~clk;

  hamming_serial_decoder_if #(.R(3), .CNT_W(8)) if0 ();
  hamming_serial_decoder_if #(.R(3), .CNT_W(8)) if1 ();
  hamming_serial_decoder_if #(.R(4), .CNT_W(8)) if2 ();
  hamming_serial_decoder #(.R(3), .EXTENDED(0), .CNT_W(8)) dut0 (.clk_in(clk), .rst_n_in(rst_n), .bus(if0));
  hamming_serial_decoder #(.R(3), .EXTENDED(1), .CNT_W(8)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .bus(if1));
  hamming_serial_decoder #(.R(4), .EXTENDED(0), .CNT_W(8)) dut2 (.clk_in(clk), .rst_n_in(rst_n), .bus(if2));

  assign if0.bit_in = b[0];
  assign if0.bit_valid_in = v[0];
  assign if0.frame_start_in = f[0];
  assign rdy[0] = if0.in_ready_out;
  assign dv[0] = if0.data_valid_out;
  assign corr[0] = if0.err_corrected_out;
  assign unc[0] = if0.err_uncorrectable_out;
  assign ovr[0] = if0.overrun_out;
  assign dat[0] = 16'(if0.data_out);
  assign syn[0] = 4'(if0.syndrome_out);
  assign cnt[0] = if0.corr_count_out;
  assign if1.bit_in = b[1];
  assign if1.bit_valid_in = v[1];
  assign if1.frame_start_in = f[1];
  assign rdy[1] = if1.in_ready_out;
  assign dv[1] = if1.data_valid_out;
  assign corr[1] = if1.err_corrected_out;
  assign unc[1] = if1.err_uncorrectable_out;
  assign ovr[1] = if1.overrun_out;
  assign dat[1] = 16'(if1.data_out);
  assign syn[1] = 4'(if1.syndrome_out);
  assign cnt[1] = if1.corr_count_out;
  assign if2.bit_in = b[2];
  assign if2.bit_valid_in = v[2];
  assign if2.frame_start_in = f[2];
  assign rdy[2] = if2.in_ready_out;
  assign dv[2] = if2.data_valid_out;
  assign corr[2] = if2.err_corrected_out;
  assign unc[2] = if2.err_uncorrectable_out;
  assign ovr[2] = if2.overrun_out;
  assign dat[2] = 16'(if2.data_out);
  assign syn[2] = 4'(if2.syndrome_out);
  assign cnt[2] = if2.corr_count_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  function automatic int flen(input int d);
    return (1 << rr[d]) - 1 + ee[d];
  endfunction

  // Reference: received bit at position p contributes p to the syndrome; classify, flip, gather data positions
  function automatic res_t model(input int d, input logic [15:0] seq);
    int n, len, s;
    logic [16:0] w;
    bit p, flip;
    res_t r;
    n = (1 << rr[d]) - 1;
    len = flen(d);
    w = '0;
    s = 0;
    p = 0;
    for (int j = 0; j < len; j++) begin
      int pos;
      pos = j < n ? j + 1 : 0;
      w[pos] = seq[len-1-j];
      p ^= w[pos];
      if (w[pos]) s ^= pos;
    end
    r.syn = 4'(s);
    r.corr = ee[d] != 0 ? p : s != 0;
    r.unc = ee[d] != 0 && s != 0 && !p;
    flip = s != 0 && (ee[d] == 0 || p);
    if (flip) w[s] = ~w[s];
    r.data = '0;
    for (int q = 1; q <= n; q++) if ((q & (q - 1)) != 0) r.data = {r.data[14:0], w[q]};
    return r;
  endfunction

  task automatic send_bits(input int d, input logic [15:0] seq, input int n, input bit fs_first);
    for (int j = 0; j < n; j++) begin
      b[d] = seq[n-1-j];
      v[d] = 1'b1;
      f[d] = fs_first && j == 0;
      tick();
    end
    v[d] = 1'b0;
    f[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [15:0] seq, input bit fs_first);
    send_bits(d, seq, flen(d), fs_first);
  endtask

  task automatic expect_frame(input int d, input res_t e, input bit b2b);
    chk("dv_early", d, 16'(dv[d]), 16'd0);
    chk("ready_in_correct", d, 16'(rdy[d]), 16'd0);
    tick();
    chk("dv_pulse", d, 16'(dv[d]), 16'd1);
    chk("data", d, dat[d], e.data);
    chk("syndrome", d, 16'(syn[d]), 16'(e.syn));
    chk("corrected", d, 16'(corr[d]), 16'(e.corr));
    chk("uncorrectable", d, 16'(unc[d]), 16'(e.unc));
    if (e.corr && exp_cnt[d] < 255) exp_cnt[d]++;
    chk("corr_count", d, 16'(cnt[d]), 16'(exp_cnt[d]));
    if (!b2b) begin
      tick();
      chk("dv_drop", d, 16'(dv[d]), 16'd0);
      chk("data_hold", d, dat[d], e.data);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("rst_ready", d, 16'(rdy[d]), 16'd1);
    chk("rst_dv", d, 16'(dv[d]), 16'd0);
    chk("rst_data", d, dat[d], 16'd0);
    chk("rst_syn", d, 16'(syn[d]), 16'd0);
    chk("rst_corr", d, 16'(corr[d]), 16'd0);
    chk("rst_unc", d, 16'(unc[d]), 16'd0);
    chk("rst_ovr", d, 16'(ovr[d]), 16'd0);
    chk("rst_cnt", d, 16'(cnt[d]), 16'd0);
  endtask

  initial begin
    logic [15:0] s1, s2;
    tbl[0] = '{0, 16'b0110011, '{16'hb, 4'd0, 1'b0, 1'b0}};
    tbl[1] = '{0, 16'b0110111, '{16'hb, 4'd5, 1'b1, 1'b0}};
    tbl[2] = '{0, 16'b1110011, '{16'hb, 4'd1, 1'b1, 1'b0}};
    tbl[3] = '{1, 16'b00100010, '{16'h9, 4'd4, 1'b0, 1'b1}};
    tbl[4] = '{1, 16'b01100111, '{16'hb, 4'd0, 1'b1, 1'b0}};
    tbl[5] = '{1, 16'b01100110, '{16'hb, 4'd0, 1'b0, 1'b0}};
    tbl[6] = '{1, 16'b01101110, '{16'hb, 4'd5, 1'b1, 1'b0}};
    tbl[7] = '{2, 16'b001100010000001, '{16'h401, 4'd0, 1'b0, 1'b0}};
    tbl[8] = '{2, 16'b001100010000101, '{16'h401, 4'd13, 1'b1, 1'b0}};
    #2;
    for (int d = 0; d < 3; d++) chk_zero(d);
    #10 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].d, tbl[i].seq, 1'b0);
      expect_frame(tbl[i].d, tbl[i].exp, 1'b0);
    end
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 15; i++) begin
        s1 = 16'($urandom) & 16'((1 << flen(d)) - 1);
        send(d, s1, 1'b0);
        expect_frame(d, model(d, s1), 1'b0);
      end
    s1 = 16'($urandom) & 16'hff;
    s2 = 16'($urandom) & 16'hff;
    send(1, s1, 1'b0);
    expect_frame(1, model(1, s1), 1'b1);
    send(1, s2, 1'b0);
    expect_frame(1, model(1, s2), 1'b0);
    chk("no_overrun_b2b", 1, 16'(ovr[1]), 16'd0);
    send_bits(0, 16'b101, 3, 1'b0);
    send(0, 16'b0110011, 1'b1);
    expect_frame(0, '{16'hb, 4'd0, 1'b0, 1'b0}, 1'b0);
    chk("ovr_before", 0, 16'(ovr[0]), 16'd0);
    send(0, 16'b0110011, 1'b0);
    b[0] = 1'b1;
    v[0] = 1'b1;
    f[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    f[0] = 1'b0;
    chk("ovr_dv", 0, 16'(dv[0]), 16'd1);
    chk("ovr_data", 0, dat[0], 16'hb);
    chk("ovr_set", 0, 16'(ovr[0]), 16'd1);
    send(0, 16'b0110111, 1'b0);
    expect_frame(0, '{16'hb, 4'd5, 1'b1, 1'b0}, 1'b0);
    chk("ovr_sticky", 0, 16'(ovr[0]), 16'd1);
    send_bits(0, 16'b1011, 4, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    chk_zero(0);
    chk_zero(1);
    for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
    #3 rst_n = 1'b1;
    tick();
    send(0, 16'b0110011, 1'b0);
    expect_frame(0, '{16'hb, 4'd0, 1'b0, 1'b0}, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send(0, 16'b0110111, 1'b0);
      expect_frame(0, '{16'hb, 4'd5, 1'b1, 1'b0}, 1'b0);
      if (i == 254) chk("count_at_255", 0, 16'(cnt[0]), 16'd255);
    end
    chk("count_saturated", 0, 16'(cnt[0]), 16'd255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
